// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the CPU MEM-stage port and the loader/debug port onto one
// 32x32 synchronous-read data memory. Each access takes IDLE -> SERVE -> RESP.
// The memory strobe is issued during SERVE, and the ack is pulsed during RESP.
//
// Build option: define ARB_FAIR_EN for round-robin arbitration between the two
// ports. Without it, the CPU always wins, and the last-grant pointer is not built.
//
// state | meaning
// IDLE  | no access in flight; grant on the first edge that sees a request
// SERVE | memory strobe cycle for the granted port (suppressed on a bad address)
// RESP  | ack/err pulse to the granted port; read data returns from memory
module mem_port_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_err_o,
    output logic        cpu_stall_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_ack_o,
    output logic        dbg_err_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [4:0]  mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Granted port: 0 = CPU, 1 = debug. It is held constant from SERVE through RESP.
    logic        gnt_dbg_q, gnt_dbg_d;

    // Attributes of the access in flight, captured when the grant is made.
    logic        acc_we_q, acc_we_d;
    logic        acc_err_q, acc_err_d;

    // High during RESP for a valid read, when memory read data is being returned.
    logic        fwd_q, fwd_d;

    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [4:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_err_q, cpu_err_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic        dbg_err_q, dbg_err_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;

    logic        launch;
    logic        launch_dbg;
    logic        arb_dbg;
    logic        other_req;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;

`ifdef ARB_FAIR_EN
    logic        last_dbg_q, last_dbg_d;

    // Round-robin: on a conflict, grant the port that did not win last time.
    always_comb begin
        arb_dbg = dbg_req_i;
        if (cpu_req_i && dbg_req_i) begin
            arb_dbg = ~last_dbg_q;
        end
    end

    // The pointer follows every grant, including back-to-back grants.
    always_comb begin
        last_dbg_d = last_dbg_q;
        if (launch) begin
            last_dbg_d = launch_dbg;
        end
    end

    // Last-grant pointer register; resets to debug so the CPU wins the first conflict.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_dbg_q <= 1'b1;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end
`else
    // Fixed priority: the CPU wins whenever it is requesting.
    always_comb begin
        arb_dbg = ~cpu_req_i;
    end
`endif

    // The other port's request is the only one that counts as new during RESP.
    // The granted port's req is still its old, just-acked access.
    always_comb begin
        other_req = gnt_dbg_q ? cpu_req_i : dbg_req_i;
    end

    // Mux the launching port's request fields and classify the address.
    always_comb begin
        sel_we    = launch_dbg ? dbg_we_i    : cpu_we_i;
        sel_addr  = launch_dbg ? dbg_addr_i  : cpu_addr_i;
        sel_wdata = launch_dbg ? dbg_wdata_i : cpu_wdata_i;
        sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:7] != 25'd0);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and grant launch.
    // From RESP, go straight back to SERVE only when the other port is requesting
    // and would also win arbitration. Under fixed priority, this keeps a CPU that
    // holds its request ahead of a waiting debug request.
    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        launch_dbg = gnt_dbg_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    state_d    = ST_SERVE;
                    launch     = 1'b1;
                    launch_dbg = arb_dbg;
                end
            end
            ST_SERVE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (other_req && (arb_dbg != gnt_dbg_q)) begin
                    state_d    = ST_SERVE;
                    launch     = 1'b1;
                    launch_dbg = arb_dbg;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered memory strobe, ack, err and rdata.
    always_comb begin
        gnt_dbg_d   = gnt_dbg_q;
        acc_we_d    = acc_we_q;
        acc_err_d   = acc_err_q;
        fwd_d       = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_ack_d   = 1'b0;
        dbg_err_d   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;

        if (launch) begin
            gnt_dbg_d   = launch_dbg;
            acc_we_d    = sel_we;
            acc_err_d   = sel_bad;
            mem_en_d    = ~sel_bad;
            mem_we_d    = sel_we & ~sel_bad;
            mem_addr_d  = sel_addr[6:2];
            mem_wdata_d = sel_wdata;
        end

        // Leaving SERVE: arm the ack. Clear rdata so writes and errors return 0.
        // A good read shows live memory data during RESP.
        if (state_q == ST_SERVE) begin
            fwd_d = ~acc_we_q & ~acc_err_q;
            if (gnt_dbg_q) begin
                dbg_ack_d   = 1'b1;
                dbg_err_d   = acc_err_q;
                dbg_rdata_d = 32'd0;
            end else begin
                cpu_ack_d   = 1'b1;
                cpu_err_d   = acc_err_q;
                cpu_rdata_d = 32'd0;
            end
        end

        // Leaving RESP after a read: keep the returned word until the next ack.
        if ((state_q == ST_RESP) && fwd_q) begin
            if (gnt_dbg_q) begin
                dbg_rdata_d = mem_rdata_i;
            end else begin
                cpu_rdata_d = mem_rdata_i;
            end
        end
    end

    // Datapath and response registers.
    // Asynchronous reset drops the memory strobe at once and cancels any pending ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt_dbg_q   <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_err_q   <= 1'b0;
            fwd_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 5'd0;
            mem_wdata_q <= 32'd0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= 32'd0;
            dbg_ack_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
            dbg_rdata_q <= 32'd0;
        end else begin
            gnt_dbg_q   <= gnt_dbg_d;
            acc_we_q    <= acc_we_d;
            acc_err_q   <= acc_err_d;
            fwd_q       <= fwd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_err_q   <= dbg_err_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Output drive. Memory read data only becomes valid in the ack cycle, so
    // during a read ack the word is passed straight through, then held.
    always_comb begin
        mem_en_o    = mem_en_q;
        mem_we_o    = mem_we_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
        cpu_ack_o   = cpu_ack_q;
        cpu_err_o   = cpu_err_q;
        cpu_rdata_o = (cpu_ack_q && fwd_q) ? mem_rdata_i : cpu_rdata_q;
        dbg_ack_o   = dbg_ack_q;
        dbg_err_o   = dbg_err_q;
        dbg_rdata_o = (dbg_ack_q && fwd_q) ? mem_rdata_i : dbg_rdata_q;
        cpu_stall_o = cpu_req_i & ~cpu_ack_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ack_o, cpu_err_o, cpu_stall_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i;
    logic [31:0] dbg_rdata_o;
    logic        dbg_ack_o, dbg_err_o;
    logic        mem_en_o, mem_we_o;
    logic [4:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_ack_o   (cpu_ack_o),
        .cpu_err_o   (cpu_err_o),
        .cpu_stall_o (cpu_stall_o),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_rdata_o (dbg_rdata_o),
        .dbg_ack_o   (dbg_ack_o),
        .dbg_err_o   (dbg_err_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata)
    );

    // 32x32 synchronous-read data memory, read-before-write, one-cycle latency.
    logic [31:0] mem [32];
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            mem_rdata <= mem[mem_addr_o];
            if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One access on the chosen port. Inputs are driven just after a rising edge and
    // held through the ack cycle. The request drops in the cycle after the ack.
    task automatic xfer(input bit dbg, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int en_cnt, output int we_cnt, output logic [4:0] maddr,
                        output logic [31:0] held);
        bit got = 0;
        lat = 0; en_cnt = 0; we_cnt = 0; maddr = 5'd0; rdata = 32'd0; err = 1'b0;
        if (dbg) begin
            dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata;
        end else begin
            cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
        end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk_i); #1;
            if (mem_en_o) begin
                en_cnt++;
                maddr = mem_addr_o;
                if (mem_we_o) we_cnt++;
            end
            if (dbg ? dbg_ack_o : cpu_ack_o) begin
                got   = 1;
                lat   = i;
                rdata = dbg ? dbg_rdata_o : cpu_rdata_o;
                err   = dbg ? dbg_err_o : cpu_err_o;
            end
        end
        check("ack_within_budget", 32'(got), 32'd1);
        @(posedge clk_i); #1;
        if (dbg) dbg_req_i = 1'b0; else cpu_req_i = 1'b0;
        held = dbg ? dbg_rdata_o : cpu_rdata_o;
    endtask

    logic [31:0] rd, held;
    logic        er;
    int          lat, en_cnt, we_cnt;
    logic [4:0]  maddr;
    int          order [6];
    int          exp_order [6];
    int          n_ack, c_n, d_n;
    bit          c_pend, d_pend;

    initial begin
        rst_i = 1'b0;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_cpu_ack", 32'(cpu_ack_o), 32'd0);
        check("rst_dbg_ack", 32'(dbg_ack_o), 32'd0);
        check("rst_cpu_err", 32'(cpu_err_o), 32'd0);
        check("rst_dbg_err", 32'(dbg_err_o), 32'd0);
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        check("rst_cpu_rdata", cpu_rdata_o, 32'd0);
        check("rst_dbg_rdata", dbg_rdata_o, 32'd0);
        check("rst_stall", 32'(cpu_stall_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Preload through the debug port: mem[0]=5, mem[2]=0x11111111.
        xfer(1, 1, 32'h0, 32'd5, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("pre0_lat", 32'(lat), 32'd2);
        xfer(1, 1, 32'h8, 32'h1111_1111, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("pre2_mem", mem[2], 32'h1111_1111);

        // CPU read of address 0, checked cycle by cycle.
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0; cpu_wdata_i = 0;
        #1;
        check("c0_stall", 32'(cpu_stall_o), 32'd1);
        check("c0_mem_en", 32'(mem_en_o), 32'd0);
        @(posedge clk_i); #1;
        check("c1_mem_en", 32'(mem_en_o), 32'd1);
        check("c1_mem_we", 32'(mem_we_o), 32'd0);
        check("c1_mem_addr", 32'(mem_addr_o), 32'd0);
        check("c1_stall", 32'(cpu_stall_o), 32'd1);
        check("c1_ack", 32'(cpu_ack_o), 32'd0);
        @(posedge clk_i); #1;
        check("c2_ack", 32'(cpu_ack_o), 32'd1);
        check("c2_rdata", cpu_rdata_o, 32'd5);
        check("c2_err", 32'(cpu_err_o), 32'd0);
        check("c2_stall", 32'(cpu_stall_o), 32'd0);
        check("c2_mem_en", 32'(mem_en_o), 32'd0);
        @(posedge clk_i); #1;
        cpu_req_i = 0;
        check("c3_ack", 32'(cpu_ack_o), 32'd0);
        check("c3_rdata_hold", cpu_rdata_o, 32'd5);

        // Debug write to 0x1C, then a CPU read of the same word.
        xfer(1, 1, 32'h1C, 32'hDEAD_BEEF, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("dw_lat", 32'(lat), 32'd2);
        check("dw_mem_addr", 32'(maddr), 32'd7);
        check("dw_we_cnt", 32'(we_cnt), 32'd1);
        check("dw_err", 32'(er), 32'd0);
        check("dw_rdata", rd, 32'd0);
        check("dw_mem7", mem[7], 32'hDEAD_BEEF);
        xfer(0, 0, 32'h1C, 32'h0, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("cr_rdata", rd, 32'hDEAD_BEEF);
        check("cr_we_cnt", 32'(we_cnt), 32'd0);
        check("cr_mem_addr", 32'(maddr), 32'd7);
        check("cr_rdata_hold", held, 32'hDEAD_BEEF);

        // Bad addresses: out of range, then misaligned.
        xfer(0, 0, 32'h82, 32'h0, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("bad82_en_cnt", 32'(en_cnt), 32'd0);
        check("bad82_err", 32'(er), 32'd1);
        check("bad82_rdata", rd, 32'd0);
        check("bad82_lat", 32'(lat), 32'd2);
        xfer(0, 1, 32'h18, 32'h0000_00AA, rd, er, lat, en_cnt, we_cnt, maddr, held);
        xfer(0, 0, 32'h18, 32'h0, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("pre_bad06_rdata", rd, 32'h0000_00AA);
        xfer(0, 0, 32'h06, 32'h0, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("bad06_en_cnt", 32'(en_cnt), 32'd0);
        check("bad06_err", 32'(er), 32'd1);
        check("bad06_rdata", rd, 32'd0);

        // Both ports request together, three accesses each.
`ifdef ARB_FAIR_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        order = '{default: 9};
        n_ack = 0; c_n = 0; d_n = 0; c_pend = 0; d_pend = 0;
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0;
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 32'h40;
        for (int cyc = 0; cyc < 60 && (c_n < 3 || d_n < 3); cyc++) begin
            @(posedge clk_i); #1;
            if (c_pend) begin
                c_pend = 0;
                if (c_n == 3) cpu_req_i = 0; else cpu_addr_i = 32'(c_n * 4);
            end
            if (d_pend) begin
                d_pend = 0;
                if (d_n == 3) dbg_req_i = 0; else dbg_addr_i = 32'h40 + 32'(d_n * 4);
            end
            if (cpu_ack_o && dbg_ack_o) check("one_ack", 32'd2, 32'd1);
            if (cpu_ack_o && n_ack < 6) begin
                order[n_ack] = 0; n_ack++; c_n++; c_pend = 1;
            end
            if (dbg_ack_o && n_ack < 6) begin
                order[n_ack] = 1; n_ack++; d_n++; d_pend = 1;
            end
        end
        check("conc_ack_count", 32'(n_ack), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ack_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
        end
        @(posedge clk_i); #1;
        cpu_req_i = 0; dbg_req_i = 0;
        @(posedge clk_i); #1;

        // Reset during SERVE of a debug write to 0x08.
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 32'h8; dbg_wdata_i = 32'hCAFE_F00D;
        @(posedge clk_i); #1;
        check("rs_serve_en", 32'(mem_en_o), 32'd1);
        #1 rst_i = 1'b0;
        #1;
        check("rs_en_async", 32'(mem_en_o), 32'd0);
        check("rs_we_async", 32'(mem_we_o), 32'd0);
        @(posedge clk_i); #1;
        check("rs_mem2_kept", mem[2], 32'h1111_1111);
        check("rs_no_ack", 32'(dbg_ack_o), 32'd0);
        rst_i = 1'b1;
        xfer(1, 1, 32'h8, 32'hCAFE_F00D, rd, er, lat, en_cnt, we_cnt, maddr, held);
        check("rs_reissue_lat", 32'(lat), 32'd2);
        check("rs_reissue_err", 32'(er), 32'd0);
        check("rs_mem2_written", mem[2], 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
